// File: rtl/timer_display.sv
// Display stage for the countdown timer: converts t to BCD with a sequential
// double-dabble engine and drives three active-low seven-segment displays.
module timer_display #(
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  t,
    input  logic        done,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [6:0]  seg_hund,
    output logic [6:0]  seg_tens,
    output logic [6:0]  seg_ones
);

    // state | meaning
    // IDLE  | wait for a new t (or the first conversion after reset)
    // LOAD  | capture t, clear accumulator and shift counter
    // SHIFT | one add-3 / shift-left step per cycle, 8 steps
    // LATCH | publish the accumulator as the new BCD value
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [31:0] BLINK_TC  = 32'(BLINK_HALF - 1);

    state_t      state_q, state_d;
    logic        init_q, init_d;
    logic [7:0]  t_prev_q, t_prev_d;
    logic [7:0]  sh_q, sh_d;
    logic [11:0] acc_q, acc_d, acc_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [31:0] blink_q, blink_d;
    logic        phase_q, phase_d;
    logic [6:0]  seg_hund_q, seg_hund_d;
    logic [6:0]  seg_tens_q, seg_tens_d;
    logic [6:0]  seg_ones_q, seg_ones_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        t_prev_d = t_prev_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        valid_d  = valid_q;
        acc_adj  = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (init_q || (t != t_prev_q))
                    state_d = LOAD;
            end
            LOAD: begin
                sh_d     = t;
                t_prev_d = t;
                acc_d    = '0;
                cnt_d    = '0;
                init_d   = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                {acc_d, sh_d} = {acc_adj[10:0], sh_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7)
                    state_d = LATCH;
            end
            LATCH: begin
                bcd_d   = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_comb begin
        blink_d = '0;
        phase_d = 1'b0;
        if (done) begin
            if (blink_q == BLINK_TC) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 32'd1;
                phase_d = phase_q;
            end
        end
    end

    // Segments are computed from next-state values so they move on the same edge as bcd.
    always_comb begin
        seg_hund_d = SEG_BLANK;
        seg_tens_d = SEG_BLANK;
        seg_ones_d = SEG_BLANK;
        if (valid_d && !phase_d) begin
            seg_ones_d = seg_decode(bcd_d[3:0]);
            if (bcd_d[11:8] != 4'd0)
                seg_hund_d = seg_decode(bcd_d[11:8]);
            if ((bcd_d[11:8] != 4'd0) || (bcd_d[7:4] != 4'd0))
                seg_tens_d = seg_decode(bcd_d[7:4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            init_q     <= 1'b1;
            t_prev_q   <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            seg_hund_q <= SEG_BLANK;
            seg_tens_q <= SEG_BLANK;
            seg_ones_q <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            t_prev_q   <= t_prev_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            seg_hund_q <= seg_hund_d;
            seg_tens_q <= seg_tens_d;
            seg_ones_q <= seg_ones_d;
        end
    end

    assign bcd      = bcd_q;
    assign busy     = busy_q;
    assign seg_hund = seg_hund_q;
    assign seg_tens = seg_tens_q;
    assign seg_ones = seg_ones_q;

endmodule
